// File: rtl/detector_tono.sv
// Square-wave period meter: counts clk cycles between synchronized rising edges of sig_in
// and reports half the accepted period, with lock tracking and a no-signal timeout.
module detector_tono #(
    parameter int CNT_W       = 29,
    parameter int MIN_PERIOD  = 4,
    parameter int TIMEOUT_CYC = 50000000,
    parameter int TOL         = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sig_in,
    input  logic             enable,
    output logic [CNT_W-1:0] half_period,
    output logic             period_valid,
    output logic             locked,
    output logic             no_signal
);

    typedef enum logic [1:0] {
        IDLE,
        WAIT_FIRST,
        MEASURE
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT_CYC - 1);
    localparam logic [CNT_W-1:0] MIN_P    = CNT_W'(MIN_PERIOD);
    localparam logic [CNT_W:0]   TOL_V    = (CNT_W + 1)'(TOL);

    state_t           state;
    logic             s1, s2, s3;
    logic [CNT_W-1:0] cnt;
    logic [1:0]       match_cnt;

    logic                    rise;
    logic [CNT_W-1:0]        period_p0;
    logic [CNT_W-1:0]        half_new_p0;
    logic signed [CNT_W:0]   delta_p0;
    logic                    period_ok_p0;
    logic                    timeout_hit;
    logic                    is_match_p0;
    logic [1:0]              match_next_p0;

    function automatic logic [CNT_W:0] abs_diff(input logic signed [CNT_W:0] d);
        abs_diff = (d < 0) ? (CNT_W + 1)'(-d) : (CNT_W + 1)'(d);
    endfunction

    function automatic logic [1:0] sat_inc2(input logic [1:0] v);
        sat_inc2 = (v >= 2'd2) ? 2'd2 : v + 2'd1;
    endfunction

    // Stage 0: synchronizer and edge detect
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= sig_in;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign rise         = s2 & ~s3;
    assign period_p0    = cnt + CNT_ONE;
    assign half_new_p0  = period_p0 >> 1;
    assign period_ok_p0 = (period_p0 >= MIN_P);
    assign timeout_hit  = (cnt == TO_LAST);
    assign delta_p0     = $signed({1'b0, half_new_p0}) - $signed({1'b0, half_period});
    assign is_match_p0  = (abs_diff(delta_p0) <= TOL_V);

    // The first measurement after arming always starts a new reference.
    always_comb begin
        match_next_p0 = 2'd1;
        if (match_cnt != 2'd0 && is_match_p0) begin
            match_next_p0 = sat_inc2(match_cnt);
        end
    end

    // Stage 1: control FSM and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            cnt          <= '0;
            match_cnt    <= 2'd0;
            half_period  <= '0;
            period_valid <= 1'b0;
            locked       <= 1'b0;
            no_signal    <= 1'b0;
        end else begin
            period_valid <= 1'b0;
            if (!enable) begin
                state       <= IDLE;
                cnt         <= '0;
                match_cnt   <= 2'd0;
                half_period <= '0;
                locked      <= 1'b0;
                no_signal   <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        cnt   <= '0;
                        state <= WAIT_FIRST;
                    end
                    WAIT_FIRST: begin
                        if (rise) begin
                            cnt       <= '0;
                            match_cnt <= 2'd0;
                            state     <= MEASURE;
                        end else if (timeout_hit) begin
                            cnt         <= '0;
                            match_cnt   <= 2'd0;
                            half_period <= '0;
                            locked      <= 1'b0;
                            no_signal   <= 1'b1;
                        end else begin
                            cnt <= cnt + CNT_ONE;
                        end
                    end
                    MEASURE: begin
                        if (rise && period_ok_p0) begin
                            cnt          <= '0;
                            half_period  <= half_new_p0;
                            period_valid <= 1'b1;
                            match_cnt    <= match_next_p0;
                            locked       <= (match_next_p0 == 2'd2);
                            no_signal    <= 1'b0;
                        end else if (timeout_hit) begin
                            // A glitch rise landing on the timeout cycle does not save it.
                            cnt         <= '0;
                            match_cnt   <= 2'd0;
                            half_period <= '0;
                            locked      <= 1'b0;
                            no_signal   <= 1'b1;
                            state       <= WAIT_FIRST;
                        end else begin
                            cnt <= cnt + CNT_ONE;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_detector_tono.sv
// Directed bench for detector_tono: a reference model pushes expected results per rise,
// a monitor pops and compares them whenever period_valid pulses.
module tb_detector_tono;

    localparam int CNT_W = 29;
    localparam int MINP  = 4;
    localparam int TO    = 1000;
    localparam int TOLV  = 1;

    logic             clk = 1'b0;
    logic             rst;
    logic             sig_in;
    logic             enable;
    logic [CNT_W-1:0] half_period;
    logic             period_valid;
    logic             locked;
    logic             no_signal;

    detector_tono #(
        .CNT_W(CNT_W), .MIN_PERIOD(MINP), .TIMEOUT_CYC(TO), .TOL(TOLV)
    ) dut (
        .clk(clk), .rst(rst), .sig_in(sig_in), .enable(enable),
        .half_period(half_period), .period_valid(period_valid),
        .locked(locked), .no_signal(no_signal)
    );

    always #5 clk = ~clk;

    typedef struct {
        int half;
        bit lck;
        bit nsig;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;

    // reference model state
    bit en_m = 0;
    bit armed = 0;
    int last_rise = 0;
    int ref_half = 0;
    int mcnt = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input longint obs, input longint expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic model_rise();
        int p, h, d;
        exp_t e;
        if (!en_m) return;
        p = cyc - last_rise;
        if (!armed || p > TO) begin
            armed = 1;
            last_rise = cyc;
            mcnt = 0;
            return;
        end
        if (p < MINP) return;
        h = p / 2;
        d = (h > ref_half) ? h - ref_half : ref_half - h;
        if (mcnt == 0) mcnt = 1;
        else if (d <= TOLV) mcnt = (mcnt >= 2) ? 2 : mcnt + 1;
        else mcnt = 1;
        ref_half = h;
        last_rise = cyc;
        e.half = h;
        e.lck = (mcnt == 2);
        e.nsig = 0;
        exp_q.push_back(e);
    endtask

    task automatic set_enable(input bit v);
        enable = v;
        en_m = v;
        if (!v) begin
            armed = 0;
            mcnt = 0;
        end
    endtask

    task automatic pulse(input int hi, input int lo);
        sig_in = 1'b1;
        model_rise();
        step(hi);
        sig_in = 1'b0;
        step(lo);
    endtask

    always @(negedge clk) begin
        if (!rst && period_valid) begin
            if (exp_q.size() == 0) begin
                check("unexpected_pulse", 1, 0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("sb_half", half_period, e.half);
                check("sb_locked", locked, e.lck);
                check("sb_no_signal", no_signal, e.nsig);
            end
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1;
        enable = 1'b0;
        sig_in = 1'b0;
        step(3);
        rst = 1'b0;
        step(1);
        check("rst_half", half_period, 0);
        check("rst_pv", period_valid, 0);
        check("rst_locked", locked, 0);
        check("rst_nosig", no_signal, 0);

        // idle with activity on sig_in
        for (int i = 0; i < 8; i++) begin
            sig_in = ~sig_in;
            step(10);
        end
        sig_in = 1'b0;
        step(5);
        check("idle_half", half_period, 0);
        check("idle_locked", locked, 0);

        // loopback 200-cycle wave
        set_enable(1'b1);
        step(5);
        pulse(100, 100);
        sig_in = 1'b1;
        model_rise();
        step(2);
        check("lat_early", period_valid, 0);
        step(1);
        check("lat_pv", period_valid, 1);
        step(1);
        check("pv_one_cycle", period_valid, 0);
        step(96);
        sig_in = 1'b0;
        step(100);
        repeat (3) pulse(100, 100);
        check("loop_half", half_period, 100);
        check("loop_locked", locked, 1);

        // frequency step to 150, then 201/203
        pulse(75, 75);
        pulse(75, 75);
        check("step_unlock", locked, 0);
        pulse(75, 75);
        check("step_relock", locked, 1);
        check("step_half", half_period, 75);
        repeat (3) pulse(100, 100);
        pulse(100, 101);
        pulse(101, 102);
        pulse(100, 100);
        check("tol_locked", locked, 1);
        check("tol_half", half_period, 101);

        // glitches: one accepted mid-period, one shorter than MIN_PERIOD
        pulse(100, 100);
        sig_in = 1'b1;
        model_rise();
        step(48);
        sig_in = 1'b0;
        step(2);
        pulse(50, 100);
        pulse(100, 100);
        sig_in = 1'b1;
        model_rise();
        step(1);
        sig_in = 1'b0;
        step(1);
        pulse(98, 100);
        pulse(100, 100);
        check("glitch_half", half_period, 100);

        // timeout and recovery
        sig_in = 1'b0;
        step(1100);
        check("to_nosig", no_signal, 1);
        check("to_locked", locked, 0);
        check("to_half", half_period, 0);
        pulse(100, 100);
        check("to_arm_nosig", no_signal, 1);
        pulse(100, 100);
        check("to_clear_nosig", no_signal, 0);
        check("to_half_back", half_period, 100);
        pulse(100, 100);

        // enable drop mid-period
        sig_in = 1'b1;
        model_rise();
        step(50);
        set_enable(1'b0);
        step(2);
        check("dis_half", half_period, 0);
        check("dis_locked", locked, 0);
        check("dis_nosig", no_signal, 0);
        sig_in = 1'b0;
        step(20);
        set_enable(1'b1);
        step(5);
        repeat (3) pulse(100, 100);
        check("reen_locked", locked, 1);

        // async reset between edges
        sig_in = 1'b1;
        model_rise();
        step(20);
        #3;
        rst = 1'b1;
        sig_in = 1'b0;
        armed = 0;
        mcnt = 0;
        #1;
        check("arst_half", half_period, 0);
        check("arst_locked", locked, 0);
        #2;
        rst = 1'b0;
        step(10);
        repeat (3) pulse(100, 100);
        check("post_rst_locked", locked, 1);
        step(5);
        check("queue_drained", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/detector_tono.md
Name: detector_tono

Overview:
- Measures the frequency of an incoming square wave, e.g. a microphone comparator output or a loopback from the speaker tone generator.
- Counts system-clock cycles between successive rising edges.
- Reports the half-period count in the same units the speaker generator takes as its max-count input, so a generator programmed with N reads back as N.
- Sits on the SoC peripheral side; firmware reads half_period, locked and no_signal through a register wrapper.

Parameters:
- CNT_W, 29, width of the period counter and of half_period.
- MIN_PERIOD, 4, shortest accepted full period in clk cycles; shorter edge intervals are glitches.
- TIMEOUT_CYC, 50000000, cycles without a rising edge before no_signal is declared. Must satisfy TIMEOUT_CYC < 2^CNT_W.
- TOL, 1, maximum |difference| between consecutive half_period values that still counts as matching for lock.

Ports:
- clk, input, 1, system clock (100 MHz).
- rst, input, 1, asynchronous active-high reset.
- sig_in, input, 1, asynchronous square wave to measure.
- enable, input, 1, measurement enable; low holds the block idle.
- half_period, output, CNT_W, last accepted full period >> 1 (floor).
- period_valid, output, 1, one-cycle pulse when half_period is updated.
- locked, output, 1, high after two consecutive accepted measurements matching within TOL.
- no_signal, output, 1, high while timed out.

Behaviour:
- Reset (async, rst=1):
  - state=IDLE.
  - Counter, synchronizer and all outputs cleared: half_period=0, period_valid=0, locked=0, no_signal=0.
- Input path:
  - Two-flop synchronizer s1→s2, plus delayed copy s3.
  - rise = s2 & ~s3.
  - No other filtering.
- Counter cnt:
  - cnt <= 0 on rise; otherwise cnt <= cnt+1.
  - Candidate period P = cnt+1 in the rise cycle, so rises T cycles apart give P=T.
- States:
  - IDLE: enable=0. cnt held 0, outputs cleared (as at reset). enable=1 → WAIT_FIRST.
  - WAIT_FIRST: first rise only arms the counter (cnt<=0), no measurement → MEASURE. cnt counts meanwhile; timeout applies as in MEASURE.
  - MEASURE, rise with P < MIN_PERIOD: rise ignored as a glitch. cnt keeps incrementing, no output change.
  - MEASURE, rise with P >= MIN_PERIOD: on the next clk edge, half_period <= P>>1 and period_valid=1 for exactly one cycle; cnt <= 0.
  - Timeout: no rise while cnt == TIMEOUT_CYC-1 → next edge: no_signal=1, locked=0, half_period=0, cnt=0, state → WAIT_FIRST.
  - Any state: enable falling → IDLE on the next edge, regardless of state.
- no_signal clears on the first accepted measurement after a timeout.
- Simultaneous rise and timeout cycle: rise wins; P=TIMEOUT_CYC is accepted if >= MIN_PERIOD.
- Lock:
  - match_cnt (0..2) increments when |new half - previous half| <= TOL, saturating at 2.
  - Otherwise match_cnt=1 (the new value becomes the reference).
  - The first measurement after WAIT_FIRST sets match_cnt=1.
  - locked = (match_cnt==2), registered together with half_period.
- Latency: from the first clk edge that samples sig_in high to period_valid high is 3 clk edges (s1, s2/rise, output register).
- Arithmetic: P and cnt are CNT_W bits; cnt cannot wrap because timeout fires first. Odd P truncates (P=7 → 3).
- rst asserted mid-measurement: everything clears immediately; no partial result is reported after release.

Test Plan:
- Reset/idle: rst pulse, enable=0, sig_in toggling every 10 cycles → all outputs 0, period_valid never asserts.
- Loopback, TIMEOUT_CYC=1000: enable=1, sig_in period 200 cycles (100 high/100 low) →
  - first rise produces no pulse;
  - each later rise gives period_valid one-cycle pulse 3 edges after sampling, half_period=100;
  - locked=1 after the second accepted pulse.
- Frequency step: period 200 → 150 → half_period=75, locked drops to 0 on the first 75 and returns to 1 on the second. Separately, period 201 then 203 (halves 100, 101, within TOL) → locked stays 1.
- Glitch: 2-cycle high pulse 50 cycles after a rise in a 200-cycle wave → that interval is still counted; a glitch rise arriving < MIN_PERIOD cycles after the previous accepted rise is ignored and half_period stays 100.
- Timeout: stop sig_in low for 1000 cycles → no_signal=1, locked=0, half_period=0; restore the 200-cycle wave → no_signal clears at the first valid measurement (second rise), half_period=100.
- Enable/reset mid-op: drop enable mid-period → IDLE, outputs 0. Re-enable → first rise arms only. Async rst pulse between clk edges → outputs 0 immediately.
